// File: rtl/texture_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : texture_stream_buffer
// Description : Ping-pong texture store. An AXI-Stream texture is written
//               into the bank the rasterizer is not reading. When the stream
//               ends, the banks swap as soon as the rasterizer is idle.
//               Reads have one cycle of latency from the active bank.
//               Optional feature macro: TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
//               (undefined: a single bank, readable while it is written).
// Revision    : 1.0 - initial release
// ============================================================================
module texture_stream_buffer #(
  parameter int STREAM_WIDTH = 16,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  input  logic                    rasterizerBusy,
  input  logic [ADDR_WIDTH-1:0]   texelAddr,
  output logic [STREAM_WIDTH-1:0] texelData,
  output logic                    activeBank,
  output logic                    textureValid,
  output logic                    overflow
);

  localparam int                    c_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic                    r_ready_en;
  logic [ADDR_WIDTH-1:0]   r_write_addr;
  logic                    r_overflow;
  logic                    r_texture_valid;
  logic [STREAM_WIDTH-1:0] r_texel_data;
  logic                    w_beat;
  logic                    w_addr_full;

  assign w_beat      = s_axis_tvalid & s_axis_tready;
  assign w_addr_full = (r_write_addr == c_ADDR_LAST);

  // Ready is held off until the first edge after reset is released
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_ready_en <= 1'b0;
    else         r_ready_en <= 1'b1;
  end

  // Write pointer: advance per beat, saturate at the last word, clear on tlast
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_write_addr <= '0;
      r_overflow   <= 1'b0;
    end else if (w_beat) begin
      if (s_axis_tlast) begin
        r_write_addr <= '0;
      end else if (w_addr_full) begin
        r_overflow   <= 1'b1;
      end else begin
        r_write_addr <= r_write_addr + c_ADDR_ONE;
      end
    end
  end

`ifdef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
  typedef enum logic [0:0] {
    RECEIVE   = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_swap;
  logic                    r_active_bank;
  logic [STREAM_WIDTH-1:0] r_mem [0:2*c_DEPTH-1];

  // Next state: park after tlast until the rasterizer lets go of the banks
  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    case (r_state)
      RECEIVE: begin
        if (w_beat && s_axis_tlast) w_state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (!rasterizerBusy) begin
          w_swap       = 1'b1;
          w_state_next = RECEIVE;
        end
      end
      default: w_state_next = RECEIVE;
    endcase
  end

  // State register
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_state <= RECEIVE;
    else         r_state <= w_state_next;
  end

  // Bank swap publishes the freshly received texture
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_active_bank   <= 1'b0;
      r_texture_valid <= 1'b0;
    end else if (w_swap) begin
      r_active_bank   <= ~r_active_bank;
      r_texture_valid <= 1'b1;
    end
  end

  assign s_axis_tready = r_ready_en & (r_state == RECEIVE);

  // Stream writes only ever target the inactive bank
  always_ff @(posedge aclk) begin
    if (w_beat) r_mem[{~r_active_bank, r_write_addr}] <= s_axis_tdata;
  end

  // Registered read from the active bank (old bank during a swap edge)
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_texel_data <= '0;
    else         r_texel_data <= r_mem[{r_active_bank, texelAddr}];
  end

  assign activeBank = r_active_bank;
`else
  logic [STREAM_WIDTH-1:0] r_mem [0:c_DEPTH-1];

  // Single bank: the texture is valid as soon as its last word lands
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn)                     r_texture_valid <= 1'b0;
    else if (w_beat && s_axis_tlast) r_texture_valid <= 1'b1;
  end

  assign s_axis_tready = r_ready_en & ~rasterizerBusy;

  // Stream writes go straight into the only bank
  always_ff @(posedge aclk) begin
    if (w_beat) r_mem[r_write_addr] <= s_axis_tdata;
  end

  // Registered read of the single bank
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_texel_data <= '0;
    else         r_texel_data <= r_mem[texelAddr];
  end

  assign activeBank = 1'b0;
`endif

  assign texelData    = r_texel_data;
  assign textureValid = r_texture_valid;
  assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_texture_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_texture_stream_buffer
// Description : Directed and random stimulus for texture_stream_buffer with a
//               queue/array based reference model of the texture store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_texture_stream_buffer;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        tvalid = 1'b0, tlast = 1'b0, busy = 1'b0;
  logic [15:0] tdata = '0;
  logic [AW-1:0] taddr = '0;
  logic        tready, abank, tex_valid, ovf;
  logic [15:0] tex;

  logic        s_valid = 1'b0, s_last = 1'b0, s_busy = 1'b0;
  logic [15:0] s_data = '0;
  logic [1:0]  s_addr = '0;
  logic        s_ready, s_bank, s_tv, s_ovf;
  logic [15:0] s_tex;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_mem [int];
  logic [15:0] m_q [$];
  bit          m_ready_en, m_wait, m_active, m_valid, m_ovf, m_known;
  logic [15:0] m_texel;

  always #5 aclk = ~aclk;

  texture_stream_buffer #(.STREAM_WIDTH(16), .ADDR_WIDTH(AW)) u_dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .s_axis_tdata(tdata), .rasterizerBusy(busy), .texelAddr(taddr),
    .texelData(tex), .activeBank(abank), .textureValid(tex_valid), .overflow(ovf)
  );

  texture_stream_buffer #(.STREAM_WIDTH(16), .ADDR_WIDTH(2)) u_small (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
    .s_axis_tdata(s_data), .rasterizerBusy(s_busy), .texelAddr(s_addr),
    .texelData(s_tex), .activeBank(s_bank), .textureValid(s_tv), .overflow(s_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tready();
`ifdef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
    return m_ready_en && !m_wait;
`else
    return m_ready_en && !busy;
`endif
  endfunction

  task automatic model_reset();
    m_mem.delete();
    m_q.delete();
    m_ready_en = 0; m_wait = 0; m_active = 0; m_valid = 0; m_ovf = 0;
    m_texel = '0; m_known = 1;
  endtask

  // One clock edge of the texture store, from the stream rules
  task automatic model_step();
    bit was_wait = m_wait;
    bit beat     = tvalid && m_tready();
    int idx;
    int key      = (m_active ? DEPTH : 0) + int'(taddr);
    if (m_mem.exists(key)) begin m_texel = m_mem[key]; m_known = 1; end
    else m_known = 0;
    if (beat) begin
      idx = (m_q.size() < DEPTH) ? m_q.size() : DEPTH - 1;
      if (idx == m_q.size()) m_q.push_back(tdata);
      else m_q[idx] = tdata;
      if (idx == DEPTH - 1 && !tlast) m_ovf = 1;
`ifndef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
      m_mem[idx] = tdata;
`endif
      if (tlast) begin
`ifdef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
        foreach (m_q[i]) m_mem[(m_active ? 0 : DEPTH) + i] = m_q[i];
        m_wait = 1;
`else
        m_valid = 1;
`endif
        m_q.delete();
      end
    end
`ifdef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
    if (was_wait && !busy) begin
      m_active = !m_active; m_valid = 1; m_wait = 0;
    end
`endif
    m_ready_en = 1;
  endtask

  task automatic check_outputs();
    check("tready", tready, m_tready());
    check("activeBank", abank, m_active);
    check("textureValid", tex_valid, m_valid);
    check("overflow", ovf, m_ovf);
    if (m_known) check("texelData", tex, m_texel);
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    @(negedge aclk);
    check_outputs();
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    tvalid = 1; tdata = d; tlast = last;
    tick();
    tvalid = 0; tlast = 0;
  endtask

  // Assert reset at a falling edge, check it acts at once, release next fall
  task automatic do_reset();
    resetn = 0;
    model_reset();
    #1;
    check_outputs();
    check("small_tready_rst", s_ready, 1'b0);
    @(posedge aclk);
    @(negedge aclk);
    resetn = 1;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge aclk);
    do_reset();
    tick();
    check("tready_after_release", tready, 1'b1);

    // four-word texture, then read it back
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 1);
`ifdef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
    check("tready_wait_swap", tready, 1'b0);
    check("bank_before_swap", abank, 1'b0);
    tick();
    check("bank_after_swap", abank, 1'b1);
`else
    check("bank_single", abank, 1'b0);
`endif
    check("valid_after_tex", tex_valid, 1'b1);
    taddr = 2;
    tick();
    check("texel_addr2", tex, 16'h3333);

`ifdef TEXTURE_STREAM_BUFFER_DOUBLE_BANK_EN
    // swap held off while the rasterizer is busy
    busy = 1;
    send(16'h5555, 0); send(16'h6666, 0); send(16'h7777, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("tready_busy_hold", tready, 1'b0);
      check("bank_busy_hold", abank, 1'b1);
    end
    busy = 0;
    tick();
    check("bank_after_busy", abank, 1'b0);
`else
    // single bank: busy gates ready
    busy = 1;
    #1;
    check("tready_busy_single", tready, 1'b0);
    busy = 0;
    #1;
    send(16'h0A0A, 0); send(16'h0B0B, 1);
    check("valid_single", tex_valid, 1'b1);
    check("bank_single_2", abank, 1'b0);
`endif

    // overflow on the small instance: six beats, tlast on the sixth
    for (int k = 0; k < 6; k++) begin
      s_valid = 1; s_data = 16'hA000 + 16'(k); s_last = (k == 5);
      tick();
      if (k == 4) check("small_overflow", s_ovf, 1'b1);
    end
    s_valid = 0; s_last = 0;
    tick(); tick();
    check("small_overflow_sticky", s_ovf, 1'b1);
    s_addr = 3;
    tick();
    check("small_addr3", s_tex, 16'hA005);

    // reset in the middle of an eight-beat stream
    send(16'hC000, 0); send(16'hC001, 0); send(16'hC002, 0);
    do_reset();
    check("bank_after_midreset", abank, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) send(16'hD000 + 16'(k), k == 7);
    tick();
    check("valid_after_fresh", tex_valid, 1'b1);
    for (int k = 0; k < 8; k++) begin
      taddr = AW'(k);
      tick();
    end

    // random traffic: reads of the active bank while streams fill the other
    for (int n = 0; n < 1500; n++) begin
      tvalid = ($urandom % 10) < 7;
      tlast  = ($urandom % 12) == 0;
      tdata  = 16'($urandom);
      if ($urandom % 8 == 0) busy = !busy;
      taddr  = AW'($urandom % 16);
      tick();
    end
    tvalid = 0; tlast = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
